// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard controller: pops bytes from the receiver FIFO, folds E0/F0
// prefixes into single key events, and tracks the held key and press count.
module ps2_kbd_ctrl #(
    parameter int              CNT_W       = 8,
    parameter int              TO_W        = 20,
    parameter logic [TO_W-1:0] TIMEOUT_CYC = 20'd500000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_ready,
    input  logic [7:0]       fifo_data,
    input  logic             fifo_overflow,
    output logic             fifo_nextdata_n,
    output logic             evt_valid,
    output logic [7:0]       evt_code,
    output logic             evt_ext,
    output logic             evt_break,
    output logic             evt_repeat,
    output logic             key_down,
    output logic [7:0]       cur_code,
    output logic             cur_ext,
    output logic [CNT_W-1:0] press_cnt,
    output logic             err_ovf,
    output logic             err_to,
    input  logic             err_clr
);

    localparam logic [7:0] CODE_EXT = 8'hE0;
    localparam logic [7:0] CODE_BRK = 8'hF0;

    typedef enum logic [1:0] {IDLE, POP, GAP, PARSE} state_t;

    state_t          state;
    logic [7:0]      byte_q;
    logic            ext_pend;
    logic            brk_pend;
    logic [TO_W-1:0] to_cnt;
    logic            to_run;
    logic            to_hit;
    logic            same_key;

    assign fifo_nextdata_n = (state != POP);
    assign to_run   = (state == IDLE) && !fifo_ready && (ext_pend || brk_pend);
    assign to_hit   = to_run && (to_cnt == TIMEOUT_CYC - 1'b1);
    assign same_key = (cur_code == byte_q) && (cur_ext == ext_pend);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            byte_q     <= '0;
            ext_pend   <= 1'b0;
            brk_pend   <= 1'b0;
            to_cnt     <= '0;
            evt_valid  <= 1'b0;
            evt_code   <= '0;
            evt_ext    <= 1'b0;
            evt_break  <= 1'b0;
            evt_repeat <= 1'b0;
            key_down   <= 1'b0;
            cur_code   <= '0;
            cur_ext    <= 1'b0;
            press_cnt  <= '0;
            err_ovf    <= 1'b0;
            err_to     <= 1'b0;
        end else begin
            evt_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (fifo_ready) begin
                        byte_q <= fifo_data;
                        state  <= POP;
                    end
                end
                POP:  state <= GAP;
                GAP:  state <= PARSE;
                PARSE: begin
                    state <= IDLE;
                    if (byte_q == CODE_EXT) begin
                        ext_pend <= 1'b1;
                    end else if (byte_q == CODE_BRK) begin
                        brk_pend <= 1'b1;
                    end else begin
                        evt_valid <= 1'b1;
                        evt_code  <= byte_q;
                        evt_ext   <= ext_pend;
                        evt_break <= brk_pend;
                        ext_pend  <= 1'b0;
                        brk_pend  <= 1'b0;
                        if (brk_pend) begin
                            evt_repeat <= 1'b0;
                            if (same_key) begin
                                key_down <= 1'b0;
                            end
                        end else if (key_down && same_key) begin
                            evt_repeat <= 1'b1;
                        end else begin
                            evt_repeat <= 1'b0;
                            press_cnt  <= press_cnt + 1'b1;
                            key_down   <= 1'b1;
                            cur_code   <= byte_q;
                            cur_ext    <= ext_pend;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // A prefix left dangling too long is dropped so it cannot taint a later key.
            if (to_hit) begin
                to_cnt   <= '0;
                ext_pend <= 1'b0;
                brk_pend <= 1'b0;
            end else if (to_run) begin
                to_cnt <= to_cnt + 1'b1;
            end else begin
                to_cnt <= '0;
            end

            if (to_hit) begin
                err_to <= 1'b1;
            end else if (err_clr) begin
                err_to <= 1'b0;
            end

            // Overflow means bytes were lost, so any half-built prefix is untrustworthy.
            if (fifo_overflow) begin
                err_ovf  <= 1'b1;
                ext_pend <= 1'b0;
                brk_pend <= 1'b0;
            end else if (err_clr) begin
                err_ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Self-checking bench for ps2_kbd_ctrl: a byte FIFO model feeds scan codes,
// a table of per-byte expectations is applied, then corner cases by hand.
module tb_ps2_kbd_ctrl;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             fifo_ready;
    logic [7:0]       fifo_data;
    logic             fifo_overflow = 1'b0;
    logic             fifo_nextdata_n;
    logic             evt_valid;
    logic [7:0]       evt_code;
    logic             evt_ext;
    logic             evt_break;
    logic             evt_repeat;
    logic             key_down;
    logic [7:0]       cur_code;
    logic             cur_ext;
    logic [CNT_W-1:0] press_cnt;
    logic             err_ovf;
    logic             err_to;
    logic             err_clr = 1'b0;

    ps2_kbd_ctrl #(
        .CNT_W      (CNT_W),
        .TO_W       (20),
        .TIMEOUT_CYC(20'd100)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fifo_ready     (fifo_ready),
        .fifo_data      (fifo_data),
        .fifo_overflow  (fifo_overflow),
        .fifo_nextdata_n(fifo_nextdata_n),
        .evt_valid      (evt_valid),
        .evt_code       (evt_code),
        .evt_ext        (evt_ext),
        .evt_break      (evt_break),
        .evt_repeat     (evt_repeat),
        .key_down       (key_down),
        .cur_code       (cur_code),
        .cur_ext        (cur_ext),
        .press_cnt      (press_cnt),
        .err_ovf        (err_ovf),
        .err_to         (err_to),
        .err_clr        (err_clr)
    );

    always #5 clk = ~clk;

    logic [7:0] fifo_mem [0:1023];
    int         wr_ptr = 0;
    int         rd_ptr = 0;

    assign fifo_ready = (wr_ptr != rd_ptr);
    assign fifo_data  = fifo_mem[rd_ptr[9:0]];

    int   checks = 0;
    int   failures = 0;
    int   evt_cnt = 0;
    int   pop_cnt = 0;
    int   wide_pop = 0;
    int   wide_evt = 0;
    bit   prev_pop = 1'b0;
    bit   prev_evt = 1'b0;
    logic [7:0] last_code = '0;
    bit   last_ext = 1'b0;
    bit   last_brk = 1'b0;
    bit   last_rep = 1'b0;

    // FIFO read side and event/strobe monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!fifo_nextdata_n) begin
            pop_cnt++;
            rd_ptr++;
            if (prev_pop) wide_pop++;
        end
        prev_pop = !fifo_nextdata_n;
        if (evt_valid) begin
            evt_cnt++;
            last_code = evt_code;
            last_ext  = evt_ext;
            last_brk  = evt_break;
            last_rep  = evt_repeat;
            if (prev_evt) wide_evt++;
        end
        prev_evt = evt_valid;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "[TB] watchdog");
    end

    typedef struct {
        logic [7:0] data;
        bit         has_evt;
        logic [7:0] code;
        bit         ext;
        bit         brk;
        bit         rep;
        bit         kd;
        logic [7:0] cur;
        bit         cext;
        logic [7:0] pc;
    } vec_t;

    function automatic vec_t mk(input logic [7:0] data, input bit has_evt, input logic [7:0] code,
                                input bit ext, input bit brk, input bit rep, input bit kd,
                                input logic [7:0] cur, input bit cext, input logic [7:0] pc);
        vec_t v;
        v.data = data; v.has_evt = has_evt; v.code = code; v.ext = ext; v.brk = brk;
        v.rep = rep; v.kd = kd; v.cur = cur; v.cext = cext; v.pc = pc;
        return v;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        fifo_mem[wr_ptr[9:0]] = b;
        wr_ptr++;
    endtask

    task automatic apply_stimulus(input vec_t v, input int idx);
        int e0;
        e0 = evt_cnt;
        push(v.data);
        repeat (5) tick();
        check_output($sformatf("v%0d evt_count", idx), evt_cnt - e0, v.has_evt ? 1 : 0);
        if (v.has_evt) begin
            check_output($sformatf("v%0d evt_code", idx), last_code, v.code);
            check_output($sformatf("v%0d evt_ext", idx), last_ext, v.ext);
            check_output($sformatf("v%0d evt_break", idx), last_brk, v.brk);
            check_output($sformatf("v%0d evt_repeat", idx), last_rep, v.rep);
        end
        check_output($sformatf("v%0d key_down", idx), key_down, v.kd);
        check_output($sformatf("v%0d cur_code", idx), cur_code, v.cur);
        check_output($sformatf("v%0d cur_ext", idx), cur_ext, v.cext);
        check_output($sformatf("v%0d press_cnt", idx), press_cnt, v.pc);
    endtask

    vec_t vecs [29];

    initial begin
        int   e0;
        int   elapsed;
        bit   found;
        logic [7:0] c;

        vecs[0]  = mk(8'h1C, 1, 8'h1C, 0, 0, 0, 1, 8'h1C, 0, 8'd1);
        vecs[1]  = mk(8'hF0, 0, 8'h00, 0, 0, 0, 1, 8'h1C, 0, 8'd1);
        vecs[2]  = mk(8'h1C, 1, 8'h1C, 0, 1, 0, 0, 8'h1C, 0, 8'd1);
        vecs[3]  = mk(8'h1C, 1, 8'h1C, 0, 0, 0, 1, 8'h1C, 0, 8'd2);
        vecs[4]  = mk(8'h1C, 1, 8'h1C, 0, 0, 1, 1, 8'h1C, 0, 8'd2);
        vecs[5]  = mk(8'h1C, 1, 8'h1C, 0, 0, 1, 1, 8'h1C, 0, 8'd2);
        vecs[6]  = mk(8'hF0, 0, 8'h00, 0, 0, 0, 1, 8'h1C, 0, 8'd2);
        vecs[7]  = mk(8'h1C, 1, 8'h1C, 0, 1, 0, 0, 8'h1C, 0, 8'd2);
        vecs[8]  = mk(8'hE0, 0, 8'h00, 0, 0, 0, 0, 8'h1C, 0, 8'd2);
        vecs[9]  = mk(8'h75, 1, 8'h75, 1, 0, 0, 1, 8'h75, 1, 8'd3);
        vecs[10] = mk(8'hE0, 0, 8'h00, 0, 0, 0, 1, 8'h75, 1, 8'd3);
        vecs[11] = mk(8'hF0, 0, 8'h00, 0, 0, 0, 1, 8'h75, 1, 8'd3);
        vecs[12] = mk(8'h75, 1, 8'h75, 1, 1, 0, 0, 8'h75, 1, 8'd3);
        vecs[13] = mk(8'h1C, 1, 8'h1C, 0, 0, 0, 1, 8'h1C, 0, 8'd4);
        vecs[14] = mk(8'hF0, 0, 8'h00, 0, 0, 0, 1, 8'h1C, 0, 8'd4);
        vecs[15] = mk(8'h33, 1, 8'h33, 0, 1, 0, 1, 8'h1C, 0, 8'd4);
        vecs[16] = mk(8'hE0, 0, 8'h00, 0, 0, 0, 1, 8'h1C, 0, 8'd4);
        vecs[17] = mk(8'hF0, 0, 8'h00, 0, 0, 0, 1, 8'h1C, 0, 8'd4);
        vecs[18] = mk(8'h1C, 1, 8'h1C, 1, 1, 0, 1, 8'h1C, 0, 8'd4);
        vecs[19] = mk(8'hE0, 0, 8'h00, 0, 0, 0, 1, 8'h1C, 0, 8'd4);
        vecs[20] = mk(8'h1C, 1, 8'h1C, 1, 0, 0, 1, 8'h1C, 1, 8'd5);
        vecs[21] = mk(8'hF0, 0, 8'h00, 0, 0, 0, 1, 8'h1C, 1, 8'd5);
        vecs[22] = mk(8'h1C, 1, 8'h1C, 0, 1, 0, 1, 8'h1C, 1, 8'd5);
        vecs[23] = mk(8'hE0, 0, 8'h00, 0, 0, 0, 1, 8'h1C, 1, 8'd5);
        vecs[24] = mk(8'hF0, 0, 8'h00, 0, 0, 0, 1, 8'h1C, 1, 8'd5);
        vecs[25] = mk(8'h1C, 1, 8'h1C, 1, 1, 0, 0, 8'h1C, 1, 8'd5);
        vecs[26] = mk(8'h1C, 1, 8'h1C, 0, 0, 0, 1, 8'h1C, 0, 8'd6);
        vecs[27] = mk(8'hF0, 0, 8'h00, 0, 0, 0, 1, 8'h1C, 0, 8'd6);
        vecs[28] = mk(8'h1C, 1, 8'h1C, 0, 1, 0, 0, 8'h1C, 0, 8'd6);

        repeat (3) tick();
        check_output("reset nextdata_n", fifo_nextdata_n, 1);
        check_output("reset evt_valid", evt_valid, 0);
        check_output("reset key_down", key_down, 0);
        check_output("reset press_cnt", press_cnt, 0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 29; i++) apply_stimulus(vecs[i], i);
        check_output("pop strobe count", pop_cnt, 29);
        check_output("pop strobe wider than 1 cycle", wide_pop, 0);
        check_output("evt_valid wider than 1 cycle", wide_evt, 0);

        // Dangling F0 must be dropped after the timeout and flagged.
        push(8'hF0);
        repeat (5) tick();
        repeat (50) tick();
        check_output("err_to before timeout", err_to, 0);
        repeat (60) tick();
        check_output("err_to after timeout", err_to, 1);
        e0 = evt_cnt;
        push(8'h1C);
        repeat (5) tick();
        check_output("post-timeout evt_count", evt_cnt - e0, 1);
        check_output("post-timeout evt_break", last_brk, 0);
        check_output("post-timeout press_cnt", press_cnt, 7);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check_output("err_to cleared", err_to, 0);

        // Overflow after E0 discards the prefix.
        push(8'hE0);
        repeat (5) tick();
        fifo_overflow = 1'b1;
        tick();
        fifo_overflow = 1'b0;
        check_output("err_ovf set", err_ovf, 1);
        check_output("key_down kept on overflow", key_down, 1);
        push(8'h74);
        repeat (5) tick();
        check_output("ovf evt_code", last_code, 8'h74);
        check_output("ovf evt_ext", last_ext, 0);
        check_output("ovf press_cnt", press_cnt, 8);
        err_clr = 1'b1;
        fifo_overflow = 1'b1;
        tick();
        err_clr = 1'b0;
        fifo_overflow = 1'b0;
        check_output("err_ovf set wins over clr", err_ovf, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check_output("err_ovf cleared", err_ovf, 0);

        // Overflow coinciding with PARSE of a terminal keeps the pre-clear prefix.
        push(8'hE0);
        repeat (5) tick();
        e0 = evt_cnt;
        push(8'h6B);
        repeat (3) tick();
        fifo_overflow = 1'b1;
        tick();
        fifo_overflow = 1'b0;
        repeat (2) tick();
        check_output("ovf+parse evt_count", evt_cnt - e0, 1);
        check_output("ovf+parse evt_ext", last_ext, 1);
        check_output("ovf+parse cur_code", cur_code, 8'h6B);
        check_output("ovf+parse err_ovf", err_ovf, 1);

        // Reset while the pop strobe is active.
        push(8'h2B);
        found = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (!fifo_nextdata_n) begin
                found = 1'b1;
                break;
            end
        end
        check_output("reached POP before reset", found, 1);
        rst = 1'b0;
        #1;
        check_output("rst nextdata_n", fifo_nextdata_n, 1);
        check_output("rst evt_valid", evt_valid, 0);
        check_output("rst evt_code", evt_code, 0);
        check_output("rst evt_ext", evt_ext, 0);
        check_output("rst evt_break", evt_break, 0);
        check_output("rst evt_repeat", evt_repeat, 0);
        check_output("rst key_down", key_down, 0);
        check_output("rst cur_code", cur_code, 0);
        check_output("rst cur_ext", cur_ext, 0);
        check_output("rst press_cnt", press_cnt, 0);
        check_output("rst err_ovf", err_ovf, 0);
        check_output("rst err_to", err_to, 0);
        e0 = evt_cnt;
        repeat (3) tick();
        rst = 1'b1;
        repeat (6) tick();
        check_output("post-rst evt_count", evt_cnt - e0, 1);
        check_output("post-rst evt_code", last_code, 8'h2B);
        check_output("post-rst evt_break", last_brk, 0);
        check_output("post-rst press_cnt", press_cnt, 1);
        check_output("post-rst key_down", key_down, 1);

        // Release 2B, then back-to-back make/break pairs up to the counter wrap.
        push(8'hF0);
        push(8'h2B);
        repeat (10) tick();
        check_output("2B released", key_down, 0);
        e0 = evt_cnt;
        for (int i = 0; i < 254; i++) begin
            c = 8'h01 + 8'(i % 96);
            push(c);
            push(8'hF0);
            push(c);
        end
        elapsed = 0;
        for (int cyc = 1; cyc <= 3100; cyc++) begin
            tick();
            if (evt_cnt - e0 >= 508) begin
                elapsed = cyc;
                break;
            end
        end
        check_output("burst event count", evt_cnt - e0, 508);
        check_output("burst cycles (4 per byte)", elapsed, 762 * 4);
        check_output("press_cnt before wrap", press_cnt, 8'd255);
        push(8'h70);
        push(8'hF0);
        push(8'h70);
        repeat (14) tick();
        check_output("press_cnt wrapped", press_cnt, 8'd0);
        check_output("key_down after last pair", key_down, 0);
        check_output("final pop strobe width", wide_pop, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_kbd_ctrl.md
Name: ps2_kbd_ctrl

Overview:
- Sequences the PS/2 receiver FIFO: pops bytes one at a time and parses the E0 (extended) and F0 (break) prefixes.
- Emits one key event per complete scan-code sequence and tracks the currently held key.
- Separates typematic repeats from genuine new presses and keeps a press counter.
- Sits between the PS/2 receiver and the display/consumer logic; the consumer sees only clean key events, never raw bytes.

Parameters:
- CNT_W, 8, width of press_cnt.
- TO_W, 20, width of the prefix timeout counter.
- TIMEOUT_CYC, 20'd500000, clk cycles a pending prefix may wait for its next byte before it is discarded.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- fifo_ready  input  1  receiver FIFO holds at least one byte.
- fifo_data  input  8  byte at the FIFO head; valid while fifo_ready=1.
- fifo_overflow  input  1  receiver overflow indication (level or pulse).
- fifo_nextdata_n  output  1  active-low pop strobe, exactly one cycle per byte.
- evt_valid  output  1  one-cycle event pulse.
- evt_code  output  8  scan code of the event (never E0 or F0).
- evt_ext  output  1  event carried an E0 prefix.
- evt_break  output  1  event is a release.
- evt_repeat  output  1  make event is a typematic repeat of the held key.
- key_down  output  1  a key is currently held.
- cur_code  output  8  code of the held or last-pressed key.
- cur_ext  output  1  extended flag of cur_code.
- press_cnt  output  CNT_W  count of distinct presses; wraps modulo 2^CNT_W.
- err_ovf  output  1  sticky; set by fifo_overflow.
- err_to  output  1  sticky; set by a prefix timeout.
- err_clr  input  1  synchronous clear of err_ovf and err_to.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE; fifo_nextdata_n=1.
  - evt_* = 0, key_down=0, cur_code=0, cur_ext=0, press_cnt=0, err_*=0.
  - Prefix flags ext_pend=0, brk_pend=0; timeout counter=0.
  - Reset in any state aborts the current byte. If the pop strobe was already issued, that byte is lost; no partial event is ever emitted.
- FSM states: IDLE, POP, GAP, PARSE. All registers are updated on posedge clk.
  - IDLE: if fifo_ready=1, latch fifo_data into byte_q and go to POP; otherwise stay.
  - POP: fifo_nextdata_n=0 for this cycle only (decoded from state); go to GAP.
  - GAP: one settle cycle so fifo_ready reflects the advanced read pointer; go to PARSE.
  - PARSE: decode byte_q; go to IDLE.
  - Throughput is one byte per 4 cycles. Back-to-back bytes cause no idle cycle beyond this.
- PARSE decode:
  - byte_q==E0: ext_pend<=1; no event.
  - byte_q==F0: brk_pend<=1; no event.
  - Any other byte is a terminal code. Registered outputs in the next cycle:
    - evt_valid=1, evt_code=byte_q, evt_ext=ext_pend, evt_break=brk_pend.
    - ext_pend and brk_pend are then cleared.
  - Make (brk_pend=0):
    - key_down=1 and cur_code/cur_ext equal the new code: evt_repeat=1; press_cnt unchanged.
    - Otherwise: evt_repeat=0, press_cnt+1, key_down<=1, cur_code<=byte_q, cur_ext<=ext_pend.
  - Break (brk_pend=1): evt_repeat=0.
    - Code and ext match cur_code/cur_ext: key_down<=0; cur_code is kept for display.
    - Mismatch: key_down is unchanged and the event is still emitted.
- evt_* fields hold their last values between pulses. Only evt_valid returns to 0 after one cycle.
- Prefix timeout:
  - The counter runs while (ext_pend|brk_pend)=1 and the FSM is in IDLE with fifo_ready=0.
  - It is cleared whenever a byte is latched or no prefix is pending.
  - On reaching TIMEOUT_CYC: clear both prefix flags, set err_to=1, emit no event.
- Overflow:
  - fifo_overflow=1 in any cycle sets err_ovf and clears both prefix flags in that cycle. key_down is unaffected.
  - If fifo_overflow and PARSE of a terminal code coincide, the event is still emitted with the pre-clear prefix values.
- err_clr:
  - Clears err_ovf and err_to.
  - If err_clr and a setting condition occur in the same cycle, set wins.
- press_cnt wraps from 2^CNT_W-1 to 0 without any flag.

Test Plan:
- Feed 1C, then F0 1C → first evt_valid with code=1C, break=0, ext=0, repeat=0; press_cnt=1, key_down=1. Second evt_valid with code=1C, break=1; key_down=0, cur_code=1C. Exactly 3 fifo_nextdata_n pulses in total, each 1 cycle wide.
- Feed 1C 1C 1C F0 1C → 3 make events with repeat=0,1,1; press_cnt=1; final key_down=0.
- Feed E0 75, then E0 F0 75 → make event with code=75, ext=1. Break event with code=75, ext=1, break=1. No events emitted for E0 or F0 bytes.
- Feed F0, then no data for TIMEOUT_CYC cycles (set to 100 in the bench), then 1C → err_to=1; the 1C yields a make event with break=0. Then err_clr=1 → err_to=0.
- Pulse fifo_overflow after E0, then feed 74 → err_ovf=1; event code=74 with ext=0. Assert err_clr and fifo_overflow in the same cycle → err_ovf stays 1.
- Drive rst=0 while in POP, then release reset with fifo_ready=1 and data 2B → all outputs at their reset values during reset. Afterwards a single clean make event for 2B; press_cnt=1.
- Issue 256 distinct make/break pairs with CNT_W=8 → press_cnt wraps to 0.
